// File: rtl/stb_edge_delay_meas.sv
// Measures and averages the delay from strobe rising edges to the first comparator rising edge.
// Optional min/max sample tracking is enabled by defining STB_EDGE_DELAY_MINMAX_EN.
`timescale 1ns/1ps

module stb_edge_delay_meas #(
    parameter int CNT_WIDTH   = 32,
    parameter int AVG_LOG2    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 arst_i,
    input  logic                 start_i,
    input  logic                 stb_i,
    input  logic                 stb_rdy_i,
    input  logic [CNT_WIDTH-1:0] stb_period_i,
    input  logic                 cmp_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 timeout_o,
`ifdef STB_EDGE_DELAY_MINMAX_EN
    output logic [CNT_WIDTH-1:0] delay_o,
    output logic [CNT_WIDTH-1:0] min_o,
    output logic [CNT_WIDTH-1:0] max_o
`else
    output logic [CNT_WIDTH-1:0] delay_o
`endif
);

    localparam int ACC_W  = CNT_WIDTH + AVG_LOG2;
    localparam int SCNT_W = AVG_LOG2 + 1;
    localparam logic [SCNT_W-1:0]    N_SAMPLES = SCNT_W'(2 ** AVG_LOG2);
    localparam logic [CNT_WIDTH-1:0] SYNC_COMP = CNT_WIDTH'(SYNC_STAGES);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        ARM,
        COUNT,
        ACCUM,
        DIVIDE,
        DONE
    } state_t;

    state_t state, next_state;

    logic                   stb_q, start_q, cmp_q;
    logic [SYNC_STAGES-1:0] cmp_sync;
    logic                   stb_rise, start_rise, cmp_rise;

    logic [CNT_WIDTH-1:0] cnt, period_q, sample;
    logic [ACC_W-1:0]     acc;
    logic [SCNT_W-1:0]    smp_cnt;

    logic clr_meas, load_cnt, inc_cnt, do_accum, do_divide, do_timeout;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            stb_q    <= 1'b0;
            start_q  <= 1'b0;
            cmp_sync <= '0;
            cmp_q    <= 1'b0;
        end else begin
            stb_q    <= stb_i;
            start_q  <= start_i;
            cmp_sync <= (cmp_sync << 1) | SYNC_STAGES'(cmp_i);
            cmp_q    <= cmp_sync[SYNC_STAGES-1];
        end
    end

    assign stb_rise   = stb_i & ~stb_q;
    assign start_rise = start_i & ~start_q;
    assign cmp_rise   = cmp_sync[SYNC_STAGES-1] & ~cmp_q;

    // Synchroniser latency is removed from each raw count, clamping at zero.
    assign sample = (cnt >= SYNC_COMP) ? (cnt - SYNC_COMP) : '0;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        clr_meas   = 1'b0;
        load_cnt   = 1'b0;
        inc_cnt    = 1'b0;
        do_accum   = 1'b0;
        do_divide  = 1'b0;
        do_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (start_rise) begin
                    next_state = WAIT_RDY;
                    clr_meas   = 1'b1;
                end
            end
            WAIT_RDY: begin
                busy_o = 1'b1;
                if (stb_rdy_i) begin
                    next_state = ARM;
                end
            end
            ARM: begin
                busy_o = 1'b1;
                if (stb_rise) begin
                    next_state = COUNT;
                    load_cnt   = 1'b1;
                end
            end
            COUNT: begin
                busy_o = 1'b1;
                // A comparator edge takes priority over the timeout limit in the same cycle.
                if (cmp_rise) begin
                    next_state = ACCUM;
                end else if ((period_q == '0) || (cnt == period_q - CNT_WIDTH'(1))) begin
                    next_state = DONE;
                    do_timeout = 1'b1;
                end else begin
                    inc_cnt = 1'b1;
                end
            end
            ACCUM: begin
                busy_o   = 1'b1;
                do_accum = 1'b1;
                if (smp_cnt + SCNT_W'(1) == N_SAMPLES) begin
                    next_state = DIVIDE;
                end else begin
                    next_state = ARM;
                end
            end
            DIVIDE: begin
                busy_o     = 1'b1;
                do_divide  = 1'b1;
                next_state = DONE;
            end
            DONE: begin
                done_o     = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            cnt       <= '0;
            period_q  <= '0;
            acc       <= '0;
            smp_cnt   <= '0;
            delay_o   <= '0;
            timeout_o <= 1'b0;
        end else begin
            if (clr_meas) begin
                acc       <= '0;
                smp_cnt   <= '0;
                timeout_o <= 1'b0;
            end
            if (load_cnt) begin
                cnt      <= '0;
                period_q <= stb_period_i;
            end
            if (inc_cnt) begin
                cnt <= cnt + CNT_WIDTH'(1);
            end
            if (do_accum) begin
                acc     <= acc + ACC_W'(sample);
                smp_cnt <= smp_cnt + SCNT_W'(1);
            end
            if (do_divide) begin
                delay_o <= CNT_WIDTH'(acc >> AVG_LOG2);
            end
            if (do_timeout) begin
                delay_o   <= '1;
                timeout_o <= 1'b1;
            end
        end
    end

`ifdef STB_EDGE_DELAY_MINMAX_EN
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            min_o <= '1;
            max_o <= '0;
        end else if (clr_meas) begin
            min_o <= '1;
            max_o <= '0;
        end else if (do_accum) begin
            if (sample < min_o) begin
                min_o <= sample;
            end
            if (sample > max_o) begin
                max_o <= sample;
            end
        end
    end
`endif

endmodule

// File: tb/tb_stb_edge_delay_meas.sv
// Directed self-checking bench for stb_edge_delay_meas (4 samples averaged, 2-stage synchroniser).
`timescale 1ns/1ps

module tb_stb_edge_delay_meas;

    logic        clk_i = 1'b0;
    logic        arst_i;
    logic        start_i;
    logic        stb_i;
    logic        stb_rdy_i;
    logic [31:0] stb_period_i;
    logic        cmp_i;
    logic        busy_o;
    logic        done_o;
    logic        timeout_o;
    logic [31:0] delay_o;
`ifdef STB_EDGE_DELAY_MINMAX_EN
    logic [31:0] min_o;
    logic [31:0] max_o;
`endif

    int vec_cnt  = 0;
    int fail_cnt = 0;
    int done_cnt = 0;
    int done_base;
    int cycles;
    logic [31:0] last_delay;
    logic        last_timeout;
    logic        last_busy;

    stb_edge_delay_meas #(
        .CNT_WIDTH  (32),
        .AVG_LOG2   (2),
        .SYNC_STAGES(2)
    ) dut (
        .clk_i       (clk_i),
        .arst_i      (arst_i),
        .start_i     (start_i),
        .stb_i       (stb_i),
        .stb_rdy_i   (stb_rdy_i),
        .stb_period_i(stb_period_i),
        .cmp_i       (cmp_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .timeout_o   (timeout_o),
`ifdef STB_EDGE_DELAY_MINMAX_EN
        .delay_o     (delay_o),
        .min_o       (min_o),
        .max_o       (max_o)
`else
        .delay_o     (delay_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Latch the result and busy level whenever a done pulse is seen mid-cycle.
    always @(negedge clk_i) begin
        if (done_o) begin
            done_cnt     <= done_cnt + 1;
            last_delay   <= delay_o;
            last_timeout <= timeout_o;
            last_busy    <= busy_o;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vec_cnt++;
        if (observed !== expected) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic startMeas();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        step();
        step();
    endtask

    // One strobe; the comparator rises in the cycle after clock edge d+1 past the strobe
    // capture edge, so the raw count is d+2 and the compensated sample is d (clamped at 0).
    task automatic applyStimulus(input int d);
        if (d + 1 <= 0) begin
            cmp_i = 1'b1;
            repeat (-(d + 1)) step();
            stb_i = 1'b1;
        end else begin
            stb_i = 1'b1;
            repeat (d + 1) step();
            cmp_i = 1'b1;
        end
        repeat (25) step();
        stb_i = 1'b0;
        cmp_i = 1'b0;
        repeat (6) step();
    endtask

    task automatic waitDoneCycles(output int n);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            n++;
            if (done_o) break;
        end
    endtask

    initial begin
        arst_i       = 1'b1;
        start_i      = 1'b0;
        stb_i        = 1'b0;
        stb_rdy_i    = 1'b1;
        stb_period_i = 32'd100;
        cmp_i        = 1'b0;
        #1;
        checkOutput("rst_busy",    busy_o,    1'b0);
        checkOutput("rst_done",    done_o,    1'b0);
        checkOutput("rst_timeout", timeout_o, 1'b0);
        checkOutput("rst_delay",   delay_o,   32'd0);
        repeat (3) step();
        arst_i = 1'b0;
        repeat (3) step();

        $display("[TB] constant delay of 10 cycles");
        done_base = done_cnt;
        startMeas();
        checkOutput("a_busy_running", busy_o, 1'b1);
        repeat (4) applyStimulus(10);
        checkOutput("a_delay",     last_delay,   32'd10);
        checkOutput("a_timeout",   last_timeout, 1'b0);
        checkOutput("a_busy_done", last_busy,    1'b0);
        checkOutput("a_done_cnt",  done_cnt - done_base, 1);

        $display("[TB] delays 10 11 12 14, sum 47");
        startMeas();
        applyStimulus(10);
        applyStimulus(11);
        applyStimulus(12);
        applyStimulus(14);
        checkOutput("b_delay", last_delay, 32'd11);
`ifdef STB_EDGE_DELAY_MINMAX_EN
        checkOutput("b_min", min_o, 32'd10);
        checkOutput("b_max", max_o, 32'd14);
`endif

        $display("[TB] comparator edge ahead of compensation");
        startMeas();
        applyStimulus(-1);
        applyStimulus(-2);
        applyStimulus(-1);
        applyStimulus(-2);
        checkOutput("sat_delay", last_delay, 32'd0);

        $display("[TB] timeout with period 50");
        stb_period_i = 32'd50;
        startMeas();
        stb_i = 1'b1;
        waitDoneCycles(cycles);
        checkOutput("to_cycles",  cycles,       51);
        step();
        checkOutput("to_delay",   last_delay,   32'hFFFF_FFFF);
        checkOutput("to_timeout", last_timeout, 1'b1);
        stb_i = 1'b0;
        repeat (4) step();

        $display("[TB] timeout with period 0");
        stb_period_i = 32'd0;
        startMeas();
        stb_i = 1'b1;
        waitDoneCycles(cycles);
        checkOutput("p0_cycles",  cycles,    2);
        checkOutput("p0_timeout", timeout_o, 1'b1);
        stb_i = 1'b0;
        stb_period_i = 32'd100;
        repeat (4) step();

        $display("[TB] late ready and start while busy");
        done_base = done_cnt;
        stb_rdy_i = 1'b0;
        startMeas();
        checkOutput("rdy_busy_wait", busy_o, 1'b1);
        repeat (5) step();
        startMeas();
        stb_i = 1'b1;
        repeat (3) step();
        stb_i = 1'b0;
        repeat (17) step();
        checkOutput("rdy_still_busy", busy_o, 1'b1);
        checkOutput("rdy_no_done",    done_cnt - done_base, 0);
        stb_rdy_i = 1'b1;
        repeat (3) step();
        repeat (4) applyStimulus(7);
        checkOutput("rdy_delay",   last_delay,   32'd7);
        checkOutput("rdy_timeout", last_timeout, 1'b0);
        repeat (30) step();
        checkOutput("rdy_one_done", done_cnt - done_base, 1);
        checkOutput("rdy_idle",     busy_o, 1'b0);

        $display("[TB] reset during COUNT");
        startMeas();
        applyStimulus(30);
        applyStimulus(30);
        stb_i = 1'b1;
        repeat (5) step();
        arst_i = 1'b1;
        #1;
        checkOutput("mid_rst_busy",    busy_o,    1'b0);
        checkOutput("mid_rst_done",    done_o,    1'b0);
        checkOutput("mid_rst_timeout", timeout_o, 1'b0);
        checkOutput("mid_rst_delay",   delay_o,   32'd0);
        step();
        step();
        stb_i  = 1'b0;
        arst_i = 1'b0;
        repeat (3) step();
        startMeas();
        repeat (4) applyStimulus(5);
        checkOutput("fresh_delay",   last_delay,   32'd5);
        checkOutput("fresh_timeout", last_timeout, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
        $finish;
    end

endmodule
